// File: rtl/s38417_match_seq.sv
// s38417_match_seq: sequences a captured sample across three reference banks
// through a registered comparator, stopping on the first hit or on timeout.
module s38417_match_seq #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         CK,
    input  logic         RST_N,
    input  logic         cfg_wr_valid,
    output logic         cfg_wr_ready,
    input  logic [1:0]   cfg_wr_bank,
    input  logic [W-1:0] cfg_wr_data,
    input  logic         start,
    input  logic [W-1:0] sample,
    input  logic         sample_valid,
    output logic [W-1:0] cmp_word,
    output logic [W-1:0] bank0_q,
    output logic [W-1:0] bank1_q,
    output logic [W-1:0] bank2_q,
    output logic [2:0]   sel_onehot,
    output logic         cmp_en,
    input  logic         match_in,
    output logic         busy,
    output logic         done,
    output logic         hit,
    output logic [1:0]   hit_bank,
    output logic         cfg_err
);
    typedef enum logic [2:0] {IDLE, CAPT, SCAN, DRAIN, DONE} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] bank0_d, bank1_d, bank2_d, cmp_word_q, cmp_word_d;
    logic [2:0]   sel_q, sel_d, prev_sel_q;
    logic [15:0]  cnt_q, cnt_d;
    logic         hit_q, hit_d, cfg_err_q, cfg_err_d, wr_acc, prev_hit;
    logic [1:0]   hit_bank_q, hit_bank_d, prev_idx;
    assign cfg_wr_ready = state_q == IDLE;
    assign wr_acc       = cfg_wr_valid && cfg_wr_ready;
    // match_in always answers for the select issued one cycle earlier
    assign prev_hit     = match_in && |prev_sel_q;
    assign prev_idx     = prev_sel_q[2] ? 2'd2 : prev_sel_q[1] ? 2'd1 : 2'd0;
    assign cmp_en       = state_q == SCAN;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign sel_onehot   = sel_q;
    assign cmp_word     = cmp_word_q;
    assign hit          = hit_q;
    assign hit_bank     = hit_bank_q;
    assign cfg_err      = cfg_err_q;
    always_comb begin
        state_d    = state_q;
        cmp_word_d = cmp_word_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        hit_d      = hit_q;
        hit_bank_d = hit_bank_q;
        cfg_err_d  = cfg_err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = CAPT;
                hit_d      = 1'b0;
                hit_bank_d = 2'd0;
                cfg_err_d  = 1'b0;
            end
            CAPT: if (sample_valid) begin
                cmp_word_d = sample;
                sel_d      = 3'b001;
                cnt_d      = 16'd0;
                state_d    = SCAN;
            end
            SCAN: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                sel_d = {sel_q[1:0], sel_q[2]};
                if (prev_hit) begin
                    hit_d      = 1'b1;
                    hit_bank_d = prev_idx;
                    sel_d      = 3'b000;
                    state_d    = DONE;
                end else if (cnt_d >= 16'(TIMEOUT)) begin
                    sel_d   = 3'b000;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (prev_hit) begin
                    hit_d      = 1'b1;
                    hit_bank_d = prev_idx;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        bank0_d = (wr_acc && cfg_wr_bank == 2'd0) ? cfg_wr_data : bank0_q;
        bank1_d = (wr_acc && cfg_wr_bank == 2'd1) ? cfg_wr_data : bank1_q;
        bank2_d = (wr_acc && cfg_wr_bank == 2'd2) ? cfg_wr_data : bank2_q;
        if (wr_acc && cfg_wr_bank == 2'd3) cfg_err_d = 1'b1;
    end
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            bank0_q    <= '0;
            bank1_q    <= '0;
            bank2_q    <= '0;
            cmp_word_q <= '0;
            sel_q      <= 3'b000;
            prev_sel_q <= 3'b000;
            cnt_q      <= 16'd0;
            hit_q      <= 1'b0;
            hit_bank_q <= 2'd0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank0_q    <= bank0_d;
            bank1_q    <= bank1_d;
            bank2_q    <= bank2_d;
            cmp_word_q <= cmp_word_d;
            sel_q      <= sel_d;
            prev_sel_q <= sel_q;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            hit_bank_q <= hit_bank_d;
            cfg_err_q  <= cfg_err_d;
        end
    end
endmodule

// File: tb/tb_s38417_match_seq.sv
// tb_s38417_match_seq: directed checks of the match sequencer against a
// registered comparator model, with TIMEOUT=6 and TIMEOUT=3 instances.
module tb_s38417_match_seq;
    logic       CK = 1'b0, RST_N = 1'b0;
    logic       cfg_wr_valid = 1'b0, start = 1'b0, sample_valid = 1'b0;
    logic [1:0] cfg_wr_bank = 2'd0;
    logic [7:0] cfg_wr_data = 8'h00, sample = 8'h00;
    logic       cfg_wr_ready, cmp_en, match_in, busy, done, hit, cfg_err;
    logic [7:0] cmp_word, bank0_q, bank1_q, bank2_q;
    logic [2:0] sel_onehot;
    logic [1:0] hit_bank;
    logic       ready3, en3, match3, busy3, done3, hit3, err3;
    logic [7:0] cw3, b03, b13, b23;
    logic [2:0] sel3;
    logic [1:0] hb3;
    int checks = 0, errors = 0;

    always #5 CK = ~CK;

    s38417_match_seq #(.W(8), .TIMEOUT(6)) dut (
        .CK(CK), .RST_N(RST_N), .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
        .cfg_wr_bank(cfg_wr_bank), .cfg_wr_data(cfg_wr_data), .start(start), .sample(sample),
        .sample_valid(sample_valid), .cmp_word(cmp_word), .bank0_q(bank0_q), .bank1_q(bank1_q),
        .bank2_q(bank2_q), .sel_onehot(sel_onehot), .cmp_en(cmp_en), .match_in(match_in),
        .busy(busy), .done(done), .hit(hit), .hit_bank(hit_bank), .cfg_err(cfg_err));

    s38417_match_seq #(.W(8), .TIMEOUT(3)) dut3 (
        .CK(CK), .RST_N(RST_N), .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(ready3),
        .cfg_wr_bank(cfg_wr_bank), .cfg_wr_data(cfg_wr_data), .start(start), .sample(sample),
        .sample_valid(sample_valid), .cmp_word(cw3), .bank0_q(b03), .bank1_q(b13),
        .bank2_q(b23), .sel_onehot(sel3), .cmp_en(en3), .match_in(match3),
        .busy(busy3), .done(done3), .hit(hit3), .hit_bank(hb3), .cfg_err(err3));

    // registered comparator: result appears one cycle after the select it answers
    always @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            match_in <= 1'b0;
            match3   <= 1'b0;
        end else begin
            match_in <= cmp_en && ((sel_onehot[0] && bank0_q == cmp_word) ||
                                   (sel_onehot[1] && bank1_q == cmp_word) ||
                                   (sel_onehot[2] && bank2_q == cmp_word));
            match3   <= en3 && ((sel3[0] && b03 == cw3) || (sel3[1] && b13 == cw3) ||
                                (sel3[2] && b23 == cw3));
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic wait_idle(input string n);
        int i;
        for (i = 0; i < 40 && (busy || busy3); i++) step();
        checks++;
        if (busy || busy3) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", n, i);
        end
    endtask

    typedef struct {
        logic       v;
        logic [1:0] b;
        logic [7:0] d;
        logic [7:0] e0, e1, e2;
        logic       eerr;
    } vec_t;
    vec_t vecs[5];
    int dn;

    initial begin
        vecs[0] = '{1'b1, 2'd0, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 2'd1, 8'h3C, 8'h5A, 8'h3C, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 2'd2, 8'hFF, 8'h5A, 8'h3C, 8'hFF, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 8'h11, 8'h5A, 8'h3C, 8'hFF, 1'b1};
        vecs[4] = '{1'b0, 2'd0, 8'h99, 8'h5A, 8'h3C, 8'hFF, 1'b1};

        #12;
        chk("reset_outs", {busy, done, hit, hit_bank, cfg_err, cmp_en, sel_onehot}, 0);
        chk("reset_ready", cfg_wr_ready, 1);
        RST_N = 1'b1;
        step();

        foreach (vecs[i]) begin
            cfg_wr_valid = vecs[i].v;
            cfg_wr_bank  = vecs[i].b;
            cfg_wr_data  = vecs[i].d;
            step();
            chk($sformatf("cfg_vec%0d", i), {bank0_q, bank1_q, bank2_q, cfg_err},
                {vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].eerr});
        end
        cfg_wr_valid = 1'b0;

        // hit on bank1
        sample = 8'h3C;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("capt_state", {busy, cfg_err, hit, cfg_wr_ready}, 4'b1000);
        sample_valid = 1'b1;
        step();
        sample = 8'h00;
        chk("s1", {cmp_en, sel_onehot, cmp_word}, {1'b1, 3'b001, 8'h3C});
        step();
        chk("s2", {cmp_en, sel_onehot, match_in}, {1'b1, 3'b010, 1'b0});
        step();
        chk("s3", {cmp_en, sel_onehot, match_in, done}, {1'b1, 3'b100, 1'b1, 1'b0});
        step();
        chk("hit_done", {done, hit, hit_bank, busy, cmp_en, sel_onehot}, {1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 3'b000});
        step();
        chk("hit_idle", {done, busy, hit, hit_bank, cfg_wr_ready}, {1'b0, 1'b0, 1'b1, 2'd1, 1'b1});
        wait_idle("hit_idle3");

        // timeout on the TIMEOUT=6 instance
        sample = 8'h00;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("to_sel%0d", i), {cmp_en, sel_onehot, done}, {1'b1, 3'b001 << (i % 3), 1'b0});
            step();
        end
        chk("to_drain", {busy, cmp_en, sel_onehot, done}, {1'b1, 1'b0, 3'b000, 1'b0});
        step();
        chk("to_done", {done, hit}, 2'b10);
        step();
        chk("to_idle", {busy, done}, 2'b00);
        wait_idle("to_idle3");

        // TIMEOUT=3: bank2 match arrives during DRAIN
        sample = 8'hFF;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("t3_s3", {en3, sel3}, {1'b1, 3'b100});
        step();
        chk("t3_drain", {busy3, en3, sel3, match3, done3}, {1'b1, 1'b0, 3'b000, 1'b1, 1'b0});
        step();
        chk("t3_done", {done3, hit3, hb3}, {1'b1, 1'b1, 2'd2});
        wait_idle("t3_idle");
        chk("t6_bank2", {hit, hit_bank}, {1'b1, 2'd2});

        // start held high, write stalled while busy
        sample = 8'h3C;
        start  = 1'b1;
        step();
        cfg_wr_valid = 1'b1;
        cfg_wr_bank  = 2'd0;
        cfg_wr_data  = 8'h77;
        dn = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            chk("stall", {cfg_wr_ready, busy, bank0_q}, {1'b0, 1'b1, 8'h5A});
            step();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL held_done: done=%0b after 20 cycles, expected 1", done);
        end
        step();
        chk("held_idle", {busy, cfg_wr_ready, done, bank0_q}, {1'b0, 1'b1, 1'b0, 8'h5A});
        step();
        chk("held_restart", {busy, bank0_q}, {1'b1, 8'h77});
        start        = 1'b0;
        cfg_wr_valid = 1'b0;
        wait_idle("held_idle2");
        chk("held_hit", {hit, hit_bank}, {1'b1, 2'd1});

        // reset mid-SCAN
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_sel", sel_onehot, 3'b010);
        #1 RST_N = 1'b0;
        #1;
        chk("rst_ctl", {busy, done, hit, hit_bank, cfg_err, cmp_en, sel_onehot}, 0);
        chk("rst_data", {bank0_q, bank1_q, bank2_q, cmp_word}, 0);
        chk("rst_ready", cfg_wr_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
